// File: rtl/priority_pkg.sv
// -----------------------------------------------------------------------------
// priority_pkg
// Shared widths, types and constants for the 4-to-2 priority encoder slice.
//   REQ_W    : number of request lines
//   IDX_W    : width of the encoded index
//   IDX_NONE : index reported whenever no request line is asserted
// -----------------------------------------------------------------------------
package priority_pkg;

  localparam int unsigned REQ_W = 4;
  localparam int unsigned IDX_W = 2;

  typedef logic [REQ_W-1:0] req_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_NONE = 2'b00;

endpackage : priority_pkg

// File: rtl/priority_4_to_2_core.sv
// -----------------------------------------------------------------------------
// priority_4_to_2_core
// Purely combinational 4-to-2 priority encoder. Bit 3 has the highest
// priority, bit 0 the lowest.
// Ports:
//   in    : request lines
//   out_c : index of the highest-priority asserted line (IDX_NONE when none)
//   v_c   : 1 when any request line is asserted
// -----------------------------------------------------------------------------
module priority_4_to_2_core
  import priority_pkg::*;
(
  input  logic [REQ_W-1:0] in,
  output logic [IDX_W-1:0] out_c,
  output logic             v_c
);

  // Ascending scan: a later (higher) set bit overwrites any lower one, so the
  // final value is the highest asserted index. Default keeps out at IDX_NONE
  // when nothing is set, so the output is never left undriven.
  always_comb begin
    out_c = IDX_NONE;
    for (int unsigned i = 0; i < REQ_W; i++) begin
      if (in[i]) begin
        out_c = idx_t'(i);
      end
    end
  end

  assign v_c = |in;

endmodule : priority_4_to_2_core

// File: rtl/priority_4_to_2.sv
// -----------------------------------------------------------------------------
// priority_4_to_2
// 4-to-2 priority encoder with valid flag and optional output register.
// Parameters:
//   REG_OUT : 1 -> out/v registered (1-cycle latency, async active-low reset)
//             0 -> out/v follow in combinationally (clk/rst_n unused)
// Ports:
//   clk   : system clock, rising-edge active
//   rst_n : asynchronous active-low reset
//   in    : request lines, bit 3 = highest priority
//   out   : binary index of the highest-priority asserted bit
//   v     : 1 when any bit of in is 1
// -----------------------------------------------------------------------------
module priority_4_to_2
  import priority_pkg::*;
#(
  parameter int unsigned REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] in,
  output logic [IDX_W-1:0] out,
  output logic             v
);

  logic [IDX_W-1:0] w_out_c;
  logic             w_v_c;

  priority_4_to_2_core u_core (
    .in    (in),
    .out_c (w_out_c),
    .v_c   (w_v_c)
  );

  if (REG_OUT != 0) begin : g_reg
    logic [IDX_W-1:0] r_out;
    logic             r_v;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out <= IDX_NONE;
        r_v   <= 1'b0;
      end else begin
        r_out <= w_out_c;
        r_v   <= w_v_c;
      end
    end

    assign out = r_out;
    assign v   = r_v;
  end else begin : g_comb
    // Clock and reset are intentionally unused in the combinational build.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;

    assign out = w_out_c;
    assign v   = w_v_c;
  end

endmodule : priority_4_to_2

// File: tb/tb_priority_4_to_2.sv
module tb_priority_4_to_2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in;
  logic [1:0] out_r, out_c;
  logic       v_r, v_c;

  int checks = 0;
  int errors = 0;

  // Expected registered outputs (value captured at the most recent edge).
  logic [1:0] exp_out_q;
  logic       exp_v_q;

  always #5 clk = ~clk;

  priority_4_to_2 #(.REG_OUT(1)) dut_r (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out_r),
    .v     (v_r)
  );

  priority_4_to_2 #(.REG_OUT(0)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out_c),
    .v     (v_c)
  );

  // Reference: index of the highest set bit by magnitude comparison.
  function automatic logic [1:0] ref_idx(input logic [3:0] x);
    int unsigned n;
    n = x;
    if (n >= 8)      return 2'd3;
    else if (n >= 4) return 2'd2;
    else if (n >= 2) return 2'd1;
    else             return 2'd0;
  endfunction

  function automatic logic ref_v(input logic [3:0] x);
    int unsigned n;
    n = x;
    return (n != 0);
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (in=%b t=%0t)", tag, obs, exp, in, $time);
    end
  endtask

  // Drive a value between edges, check hold/latency and the comb path,
  // then check the registered result one edge later.
  task automatic apply(input logic [3:0] val, input string tag);
    @(negedge clk);
    in = val;
    #1;
    chk({tag, "_hold_out"}, out_r, exp_out_q);
    chk({tag, "_hold_v"}, {1'b0, v_r}, {1'b0, exp_v_q});
    chk({tag, "_comb_out"}, out_c, ref_idx(val));
    chk({tag, "_comb_v"}, {1'b0, v_c}, {1'b0, ref_v(val)});
    @(posedge clk);
    #1;
    exp_out_q = ref_idx(val);
    exp_v_q   = ref_v(val);
    chk({tag, "_reg_out"}, out_r, exp_out_q);
    chk({tag, "_reg_v"}, {1'b0, v_r}, {1'b0, exp_v_q});
  endtask

  initial begin
    logic [3:0] mask_vals [3];
    logic [3:0] rv;

    // Reset held with all requests active.
    rst_n = 1'b1;
    in    = 4'b1111;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_out", out_r, 2'b00);
    chk("rst_async_v", {1'b0, v_r}, 2'b00);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_hold_out", out_r, 2'b00);
      chk("rst_hold_v", {1'b0, v_r}, 2'b00);
      chk("rst_comb_out", out_c, 2'b11);
      chk("rst_comb_v", {1'b0, v_c}, 2'b01);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_pre_out", out_r, 2'b00);
    @(posedge clk);
    #1;
    chk("rst_rel_out", out_r, 2'b11);
    chk("rst_rel_v", {1'b0, v_r}, 2'b01);
    exp_out_q = 2'b11;
    exp_v_q   = 1'b1;

    // Priority walk-down.
    apply(4'b1111, "walk3");
    apply(4'b0111, "walk2");
    apply(4'b0011, "walk1");
    apply(4'b0001, "walk0");

    // Empty.
    apply(4'b0000, "empty");

    // Lower bits masked by a higher one.
    mask_vals[0] = 4'b1011;
    mask_vals[1] = 4'b0101;
    mask_vals[2] = 4'b1110;
    for (int i = 0; i < 3; i++) apply(mask_vals[i], "mask");

    // Exhaustive.
    for (int i = 0; i < 16; i++) apply(4'(i), "exh");

    // Async reset mid-stream.
    apply(4'b0111, "mid_pre");
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", out_r, 2'b00);
    chk("mid_rst_v", {1'b0, v_r}, 2'b00);
    chk("mid_rst_comb_out", out_c, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_pre_out", out_r, 2'b00);
    chk("mid_rel_pre_v", {1'b0, v_r}, 2'b00);
    @(posedge clk);
    #1;
    chk("mid_rel_out", out_r, 2'b10);
    chk("mid_rel_v", {1'b0, v_r}, 2'b01);
    exp_out_q = 2'b10;
    exp_v_q   = 1'b1;

    // Randomized stream.
    for (int i = 0; i < 40; i++) begin
      rv = 4'($urandom_range(0, 15));
      apply(rv, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_priority_4_to_2
